// File: rtl/cook_controller.sv
// Microwave cook controller: BCD keypad time entry, countdown in COOK, pause/resume on door
// or stop, duty-cycled magnetron over a 10-second phase window.
module cook_controller #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic [3:0]  power_level,
  output logic        mag_on,
  output logic [15:0] time_bcd,
  output logic [1:0]  state,
  output logic        done
);

  localparam int unsigned TickW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCook  = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      time_q, time_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [3:0]       phase_q, phase_d;
  logic             mag_q, mag_d;
  logic             done_q, done_d;
  logic             startn_q, stopn_q, clearn_q;

  logic             clear_press, stop_press, start_press, any_press;
  logic             tick_wrap;
  logic [15:0]      time_dec;
  logic [3:0]       eff_power;

  // Edge-detected presses, resolved so at most one of clear/stop/start is seen per cycle.
  assign clear_press = clearn_q & ~clearn;
  assign stop_press  = stopn_q & ~stopn & ~clear_press;
  assign start_press = startn_q & ~startn & ~clear_press & ~stop_press;
  assign any_press   = (clearn_q & ~clearn) | (stopn_q & ~stopn) | (startn_q & ~startn);

  assign tick_wrap = (tick_q == TickW'(TICKS_PER_SEC - 1));
  assign eff_power = ((power_level == 4'd0) || (power_level > 4'd10)) ? 4'd10 : power_level;

  // One-second BCD decrement; out-of-range entries like sec 99 simply count down digit-wise.
  always_comb begin
    time_dec = time_q;
    if (time_q[3:0] != 4'd0) begin
      time_dec[3:0] = time_q[3:0] - 4'd1;
    end else if (time_q[7:4] != 4'd0) begin
      time_dec[7:4] = time_q[7:4] - 4'd1;
      time_dec[3:0] = 4'd9;
    end else begin
      time_dec[7:0] = 8'h59;
      if (time_q[11:8] != 4'd0) begin
        time_dec[11:8] = time_q[11:8] - 4'd1;
      end else begin
        time_dec[11:8]  = 4'd9;
        time_dec[15:12] = time_q[15:12] - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tick_d  = tick_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_press) begin
          time_d = 16'h0000;
        end else if (start_press) begin
          if (door_closed && (time_q != 16'h0000)) begin
            state_d = StCook;
            tick_d  = '0;
            phase_d = 4'd0;
          end
        end else if (key_valid && (key_digit <= 4'd9)) begin
          time_d = {time_q[11:0], key_digit};
        end
      end
      StCook: begin
        if (clear_press) begin
          state_d = StIdle;
          time_d  = 16'h0000;
        end else if (stop_press || !door_closed) begin
          state_d = StPause;
        end else if (tick_wrap) begin
          tick_d  = '0;
          time_d  = time_dec;
          phase_d = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
          if (time_dec == 16'h0000) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      StPause: begin
        if (clear_press || stop_press) begin
          state_d = StIdle;
          time_d  = 16'h0000;
        end else if (start_press && door_closed) begin
          state_d = StCook;
          tick_d  = '0;
          phase_d = 4'd0;
        end
      end
      StDone: begin
        if (any_press || !door_closed) begin
          state_d = StIdle;
          time_d  = 16'h0000;
        end
      end
      default: state_d = StIdle;
    endcase
    mag_d = (state_d == StCook) && (phase_d < eff_power);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      time_q   <= 16'h0000;
      tick_q   <= '0;
      phase_q  <= 4'd0;
      mag_q    <= 1'b0;
      done_q   <= 1'b0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      clearn_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      tick_q   <= tick_d;
      phase_q  <= phase_d;
      mag_q    <= mag_d;
      done_q   <= done_d;
      startn_q <= startn;
      stopn_q  <= stopn;
      clearn_q <= clearn;
    end
  end

  // Door gating is combinational so opening the door drops the magnetron immediately.
  assign mag_on   = mag_q & door_closed;
  assign time_bcd = time_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cook_controller.sv
// Scoreboard bench for cook_controller: expectations are queued as stimulus is applied and
// compared against the DUT outputs after the clock edge that should produce them.
module tb_cook_controller;

  localparam int unsigned T = 4;
  localparam logic [1:0] SIdle = 2'b00, SCook = 2'b01, SPause = 2'b10, SDone = 2'b11;

  logic        clk = 1'b0;
  logic        rst, startn, stopn, clearn, door_closed, key_valid;
  logic [3:0]  key_digit, power_level;
  logic        mag_on, done;
  logic [15:0] time_bcd;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  cook_controller #(.TICKS_PER_SEC(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .power_level (power_level),
    .mag_on      (mag_on),
    .time_bcd    (time_bcd),
    .state       (state),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_all(input string tag, input logic [1:0] st, input logic [15:0] tm,
                         input logic mg, input logic dn);
    push({tag, ".state"}, 0, {14'd0, st});
    push({tag, ".time"}, 1, tm);
    push({tag, ".mag"}, 2, {15'd0, mg});
    push({tag, ".done"}, 3, {15'd0, dn});
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = {14'd0, state};
        1:       obs = time_bcd;
        2:       obs = {15'd0, mag_on};
        default: obs = {15'd0, done};
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    startn = 1'b0;
    step(1);
    startn = 1'b1;
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    step(1);
    stopn = 1'b1;
  endtask

  task automatic press_clear();
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; key_valid = 1'b0; key_digit = 4'd0; power_level = 4'd10;
    step(2);
    rst = 1'b0;
    exp_all("reset", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();

    // Full 1:30 cook to DONE at full power
    key(4'd1); key(4'd3); key(4'd0);
    exp_all("entry", SIdle, 16'h0130, 1'b0, 1'b0);
    drain();
    press_start();
    exp_all("start", SCook, 16'h0130, 1'b1, 1'b0);
    drain();
    step(T);
    push("one_sec.time", 1, 16'h0129);
    drain();
    step(90 * T - 1 - T);
    exp_all("pre_done", SCook, 16'h0001, 1'b1, 1'b0);
    drain();
    step(1);
    exp_all("done", SDone, 16'h0000, 1'b0, 1'b1);
    drain();
    step(1);
    exp_all("done_after", SDone, 16'h0000, 1'b0, 1'b0);
    drain();

    // Minute borrow, invalid digit, start+clear collision, held start
    press_clear();
    exp_all("done_clear", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();
    key(4'hA);
    push("bad_digit.time", 1, 16'h0000);
    drain();
    key(4'd1); key(4'd0); key(4'd0);
    press_start();
    step(T);
    exp_all("borrow", SCook, 16'h0059, 1'b1, 1'b0);
    drain();
    startn = 1'b0;
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    exp_all("start_clear", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();
    step(50);
    exp_all("held_start", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();
    startn = 1'b1;
    step(1);

    // Sec 99 counts down as entered
    key(4'd9); key(4'd9);
    press_start();
    step(T);
    push("sec99.time", 1, 16'h0098);
    drain();
    press_clear();
    exp_all("cook_clear", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();

    // Power 3 duty over 5 seconds, then door open from DONE
    power_level = 4'd3;
    key(4'd0); key(4'd5);
    press_start();
    cnt = int'(mag_on);
    for (int i = 1; i < 5 * T; i++) begin
      step(1);
      cnt += int'(mag_on);
    end
    check("mag_duty", 16'(cnt), 16'(3 * T));
    step(1);
    exp_all("duty_done", SDone, 16'h0000, 1'b0, 1'b1);
    drain();
    door_closed = 1'b0;
    step(1);
    exp_all("done_door", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();
    door_closed = 1'b1;
    power_level = 4'd10;

    // Door open mid-cook pauses, resume, stop twice
    key(4'd2); key(4'd5);
    press_start();
    step(5 * T);
    exp_all("at_0020", SCook, 16'h0020, 1'b1, 1'b0);
    drain();
    door_closed = 1'b0;
    #1;
    exp_all("door_comb", SCook, 16'h0020, 1'b0, 1'b0);
    drain();
    step(1);
    exp_all("door_pause", SPause, 16'h0020, 1'b0, 1'b0);
    drain();
    step(3);
    push("pause_hold.time", 1, 16'h0020);
    drain();
    door_closed = 1'b1;
    step(1);
    press_start();
    exp_all("resume", SCook, 16'h0020, 1'b1, 1'b0);
    drain();
    step(T);
    push("resume_dec.time", 1, 16'h0019);
    drain();
    press_stop();
    exp_all("stop_pause", SPause, 16'h0019, 1'b0, 1'b0);
    drain();
    step(1);
    press_stop();
    exp_all("stop_idle", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();

    // Reset mid-cook with start held
    key(4'd4); key(4'd5);
    press_start();
    step(2);
    rst = 1'b1;
    startn = 1'b0;
    step(1);
    exp_all("mid_rst", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();
    rst = 1'b0;
    step(5);
    exp_all("rst_held", SIdle, 16'h0000, 1'b0, 1'b0);
    drain();
    startn = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
